tx_arbiter: RTL and testbench
=============================

TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter REQ_COUNT, default 4, number of byte-stream requesters sharing one uart_tx (range 2..8).
REQ-002 Parameter GAP_TIMEOUT, default 255, idle clk cycles allowed mid-frame before the frame is aborted (range 1..65535).
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port req_valid  input  REQ_COUNT  requester i presents a byte.
REQ-006 Port req_data  input  8*REQ_COUNT  byte of requester i at [8*i+:8].
REQ-007 Port req_last  input  REQ_COUNT  presented byte is the last byte of its frame.
REQ-008 Port req_ready  output  REQ_COUNT  one-cycle accept strobe to requester i.
REQ-009 Port tx_done  input  1  uart_tx idle flag (high when idle, low while shifting).
REQ-010 Port tx_data  output  8  byte to uart_tx.
REQ-011 Port tx_data_ready  output  1  one-cycle start strobe to uart_tx.
REQ-012 Port grant_valid  output  1  a requester currently owns the transmitter.
REQ-013 Port grant_id  output  $clog2(REQ_COUNT)  index of current owner.
REQ-014 Port frame_abort  output  1  one-cycle pulse when a frame is dropped on gap timeout.

Function
REQ-015 The block SHALL implement states IDLE, GRANT, WAIT_LOW, WAIT_HIGH; all outputs registered.
REQ-016 IDLE: if any req_valid bit set, SHALL pick the first set bit searching ptr+1, ptr+2, ... modulo REQ_COUNT, load grant_id, set grant_valid, clear gap counter, go to GRANT next cycle; otherwise stay.
REQ-017 GRANT: if req_valid[grant_id] and tx_done are both high, SHALL pulse req_ready[grant_id] for exactly that cycle (registered, so the strobe appears the following cycle) and capture req_data/req_last of the owner.
REQ-018 Accept SHALL be followed one cycle later by tx_data updated to the captured byte and tx_data_ready high for exactly one cycle; state then WAIT_LOW.
REQ-019 Latency: req_valid rising in IDLE at cycle 0 SHALL give req_ready at cycle 2 and tx_data_ready at cycle 3 when tx_done is high throughout.
REQ-020 WAIT_LOW: SHALL wait for tx_done low, then go to WAIT_HIGH; no further tx_data_ready while not in GRANT.
REQ-021 WAIT_HIGH: on tx_done high, if captured last flag set SHALL set ptr to grant_id, clear grant_valid, return to IDLE; else return to GRANT with gap counter cleared.
REQ-022 GRANT with req_valid[grant_id] low SHALL increment the gap counter; on reaching GAP_TIMEOUT SHALL pulse frame_abort, set ptr to grant_id, clear grant_valid, return to IDLE.
REQ-023 Grant SHALL be frame-locked: requests from other requesters SHALL be ignored until the owner's last byte completes or abort fires.
REQ-024 req_ready SHALL be one-hot or zero, never asserted outside GRANT-accept, never to a non-owner.
REQ-025 req_valid/req_data changes during WAIT_LOW/WAIT_HIGH SHALL have no effect; req_data is sampled only at accept.
REQ-026 Simultaneous requests in IDLE SHALL be resolved only by round-robin order; ptr wraps from REQ_COUNT-1 to 0.
REQ-027 tx_data SHALL hold its last value between bytes.

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, tx_data 8'hFF, tx_data_ready 0, req_ready 0, grant_valid 0, grant_id 0, frame_abort 0, gap counter 0, ptr REQ_COUNT-1 (requester 0 first).
REQ-029 Reset mid-frame SHALL drop the frame with no frame_abort pulse; a byte already handed to uart_tx is not recalled.
REQ-030 After rst_n rises, first arbitration SHALL occur on the first clk edge with any req_valid set.

Verification
REQ-031 Single: req 1 sends 3-byte frame 0x41,0x42,0x43(last), uart model 10-cycle busy -> three tx_data_ready pulses with those bytes in order, grant_id 1 throughout, grant_valid low after third tx_done rise.
REQ-032 Contention: all four assert valid with 1-byte frames after reset -> grant order 0,1,2,3; then req 0 again -> order resumes at 0 after 3.
REQ-033 Frame lock: req 2 mid-frame, req 0 asserts valid -> no req_ready[0] until req 2 last byte completes; then grant_id 0 (after 3 skipped if idle).
REQ-034 Gap timeout GAP_TIMEOUT=8: owner drops valid after first byte -> frame_abort pulse on 8th idle cycle in GRANT, grant_valid 0 same cycle, next requester granted.
REQ-035 Backpressure: tx_done held low in GRANT with valid high -> no req_ready, no tx_data_ready, gap counter not incremented.
REQ-036 Reset mid-frame: rst_n low during WAIT_HIGH -> all outputs at reset values asynchronously, tx_data 0xFF, no frame_abort.

Source files
------------

// File: rtl/tx_arbiter_if.sv
// tx_arbiter_if: byte-stream requesters + uart_tx handshake bundle.
// master: arbiter side (drives req_ready, tx_*, grant_*, frame_abort).
// slave: requesters and uart_tx side (drives req_*, tx_done).
interface tx_arbiter_if #(
  parameter int REQ_COUNT = 4
);
  localparam int IDW = $clog2(REQ_COUNT);

  logic [REQ_COUNT-1:0]   req_valid;
  logic [8*REQ_COUNT-1:0] req_data;
  logic [REQ_COUNT-1:0]   req_last;
  logic [REQ_COUNT-1:0]   req_ready;
  logic                   tx_done;
  logic [7:0]             tx_data;
  logic                   tx_data_ready;
  logic                   grant_valid;
  logic [IDW-1:0]         grant_id;
  logic                   frame_abort;

  modport master (
    input  req_valid,
    input  req_data,
    input  req_last,
    input  tx_done,
    output req_ready,
    output tx_data,
    output tx_data_ready,
    output grant_valid,
    output grant_id,
    output frame_abort
  );

  modport slave (
    output req_valid,
    output req_data,
    output req_last,
    output tx_done,
    input  req_ready,
    input  tx_data,
    input  tx_data_ready,
    input  grant_valid,
    input  grant_id,
    input  frame_abort
  );
endinterface

// File: rtl/tx_arbiter.sv
// tx_arbiter: frame-locked round-robin arbiter sharing one uart_tx.
// Ports: clk, rst_n (async, active-low), bus (tx_arbiter_if.master):
//   req_valid/req_data/req_last in, req_ready out, tx_done in,
//   tx_data/tx_data_ready out, grant_valid/grant_id/frame_abort out.
module tx_arbiter #(
  parameter int REQ_COUNT   = 4,
  parameter int GAP_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  tx_arbiter_if.master bus
);
  localparam int IDW = $clog2(REQ_COUNT);

  typedef logic [IDW-1:0] id_t;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    WAIT_LOW,
    WAIT_HIGH
  } state_t;

  localparam logic [15:0] GAP_LAST =
    16'(GAP_TIMEOUT - 1);
  localparam logic [REQ_COUNT-1:0] ONE =
    REQ_COUNT'(1);
  localparam id_t PTR_RST = id_t'(REQ_COUNT - 1);

  state_t               state_q, state_d;
  id_t                  ptr_q, ptr_d;
  id_t                  gid_q, gid_d;
  logic                 gv_q, gv_d;
  logic [15:0]          gap_q, gap_d;
  logic [7:0]           cap_data_q, cap_data_d;
  logic                 cap_last_q, cap_last_d;
  logic [7:0]           txd_q, txd_d;
  logic                 txr_q, txr_d;
  logic [REQ_COUNT-1:0] rdy_q, rdy_d;
  logic                 abort_q, abort_d;

  logic                 pick_hit;
  id_t                  pick_id;
  int                   idx;

  logic                 own_valid;
  logic                 own_last;
  logic [7:0]           own_data;

  assign own_valid = bus.req_valid[gid_q];
  assign own_last  = bus.req_last[gid_q];
  assign own_data  = bus.req_data[{gid_q, 3'b000} +: 8];

  // Scan from the farthest slot back to ptr+1 so the
  // nearest requester after ptr is the last one written.
  always_comb begin
    pick_hit = 1'b0;
    pick_id  = '0;
    idx      = 0;
    for (int k = REQ_COUNT; k >= 1; k--) begin
      idx = (int'(ptr_q) + k) % REQ_COUNT;
      if (bus.req_valid[id_t'(idx)]) begin
        pick_hit = 1'b1;
        pick_id  = id_t'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gid_d      = gid_q;
    gv_d       = gv_q;
    gap_d      = gap_q;
    cap_data_d = cap_data_q;
    cap_last_d = cap_last_q;
    txd_d      = txd_q;
    txr_d      = 1'b0;
    rdy_d      = '0;
    abort_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_hit) begin
          gid_d   = pick_id;
          gv_d    = 1'b1;
          gap_d   = '0;
          state_d = GRANT;
        end
      end

      GRANT: begin
        // A strobe still showing means the byte was taken
        // last cycle: hand it to uart_tx instead of re-accepting.
        if (rdy_q != '0) begin
          txd_d   = cap_data_q;
          txr_d   = 1'b1;
          state_d = WAIT_LOW;
        end else if (own_valid && bus.tx_done) begin
          rdy_d      = ONE << gid_q;
          cap_data_d = own_data;
          cap_last_d = own_last;
          gap_d      = '0;
        end else if (!own_valid) begin
          if (gap_q >= GAP_LAST) begin
            abort_d = 1'b1;
            ptr_d   = gid_q;
            gv_d    = 1'b0;
            gap_d   = '0;
            state_d = IDLE;
          end else begin
            gap_d = gap_q + 16'd1;
          end
        end
      end

      WAIT_LOW: begin
        if (!bus.tx_done) begin
          state_d = WAIT_HIGH;
        end
      end

      WAIT_HIGH: begin
        if (bus.tx_done) begin
          if (cap_last_q) begin
            ptr_d   = gid_q;
            gv_d    = 1'b0;
            state_d = IDLE;
          end else begin
            gap_d   = '0;
            state_d = GRANT;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= PTR_RST;
      gid_q      <= '0;
      gv_q       <= 1'b0;
      gap_q      <= '0;
      cap_data_q <= 8'h00;
      cap_last_q <= 1'b0;
      txd_q      <= 8'hFF;
      txr_q      <= 1'b0;
      rdy_q      <= '0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gid_q      <= gid_d;
      gv_q       <= gv_d;
      gap_q      <= gap_d;
      cap_data_q <= cap_data_d;
      cap_last_q <= cap_last_d;
      txd_q      <= txd_d;
      txr_q      <= txr_d;
      rdy_q      <= rdy_d;
      abort_q    <= abort_d;
    end
  end

  assign bus.req_ready     = rdy_q;
  assign bus.tx_data       = txd_q;
  assign bus.tx_data_ready = txr_q;
  assign bus.grant_valid   = gv_q;
  assign bus.grant_id      = gid_q;
  assign bus.frame_abort   = abort_q;

  a_rdy_onehot: assert property (
    @(posedge clk) disable iff (!rst_n)
    $onehot0(rdy_q)
  );

  a_rdy_owner: assert property (
    @(posedge clk) disable iff (!rst_n)
    (rdy_q != '0) |-> (gv_q && rdy_q == (ONE << gid_q))
  );
endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed frames through a queued requester model
// and a 10-cycle uart model; monitor pops expected bytes from exp_q.
module tb_tx_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tx_arbiter_if #(.REQ_COUNT(N)) bus ();

  tx_arbiter #(
    .REQ_COUNT(N),
    .GAP_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int abort_cnt = 0;
  int busy = 0;
  logic hold_low = 1'b0;

  logic [9:0] exp_q [$];
  logic [8:0] mem [N][32];
  logic [4:0] head [N] = '{default: 5'd0};
  logic [4:0] tail [N] = '{default: 5'd0};
  logic [N-1:0] one = 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [7:0] d,
                      input logic last, input bit expect_it);
    mem[id][tail[id]] = {last, d};
    tail[id] = tail[id] + 5'd1;
    if (expect_it) exp_q.push_back({2'(id), d});
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < N; i++)
      if (head[i] != tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_tx_data"}, bus.tx_data, 8'hFF);
    check({tag, "_tx_data_ready"}, bus.tx_data_ready, 0);
    check({tag, "_req_ready"}, bus.req_ready, 0);
    check({tag, "_grant_valid"}, bus.grant_valid, 0);
    check({tag, "_grant_id"}, bus.grant_id, 0);
    check({tag, "_frame_abort"}, bus.frame_abort, 0);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.grant_valid &&
          bus.tx_done && queues_empty()) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_idle"}, 32'(ok), 1);
  endtask

  task automatic wait_txdr(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.tx_data_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_txdr_seen"}, 32'(ok), 1);
  endtask

  assign bus.tx_done = (busy == 0) && !hold_low;

  always @(posedge clk) begin
    if (bus.tx_data_ready) busy <= 10;
    else if (busy != 0) busy <= busy - 1;
  end

  // requester model: present queue head, pop on req_ready
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (bus.req_ready[2'(i)] && head[i] != tail[i])
          head[i] = head[i] + 5'd1;
        if (head[i] != tail[i]) begin
          bus.req_valid[2'(i)] = 1'b1;
          bus.req_last[2'(i)]  = mem[i][head[i]][8];
          bus.req_data[{2'(i), 3'b000} +: 8] =
            mem[i][head[i]][7:0];
        end else begin
          bus.req_valid[2'(i)] = 1'b0;
          bus.req_last[2'(i)]  = 1'b0;
          bus.req_data[{2'(i), 3'b000} +: 8] = 8'h00;
        end
      end
    end
  end

  // monitor / scoreboard
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (bus.tx_data_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_tx: got id %0d byte %0h expected none",
                   bus.grant_id, bus.tx_data);
        end else begin
          e = exp_q.pop_front();
          check("tx_id_byte", {bus.grant_id, bus.tx_data}, e);
          check("tx_grant_valid", bus.grant_valid, 1);
        end
      end
      if (bus.req_ready != '0) begin
        check("ready_owner", bus.req_ready,
              32'(one << bus.grant_id));
        check("ready_grant_valid", bus.grant_valid, 1);
      end
      if (bus.frame_abort) begin
        abort_cnt++;
        check("abort_grant_valid", bus.grant_valid, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_hits, txr_hits, abt_hits;
    bit ok;

    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // single 3-byte frame from requester 1, latency 2/3
    @(posedge clk);
    #1;
    push(1, 8'h41, 1'b0, 1'b1);
    push(1, 8'h42, 1'b0, 1'b1);
    push(1, 8'h43, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("lat_c1_grant_valid", bus.grant_valid, 1);
    check("lat_c1_grant_id", bus.grant_id, 1);
    check("lat_c1_req_ready", bus.req_ready, 0);
    @(posedge clk);
    #1;
    check("lat_c2_req_ready", bus.req_ready, 4'b0010);
    check("lat_c2_tx_data_ready", bus.tx_data_ready, 0);
    @(posedge clk);
    #1;
    check("lat_c3_tx_data_ready", bus.tx_data_ready, 1);
    check("lat_c3_tx_data", bus.tx_data, 8'h41);
    wait_idle("single");

    // contention after reset: 0,1,2,3 then 0 before 2
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst2_grant_valid", bus.grant_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    push(0, 8'hA0, 1'b1, 1'b1);
    push(1, 8'hA1, 1'b1, 1'b1);
    push(2, 8'hA2, 1'b1, 1'b1);
    push(3, 8'hA3, 1'b1, 1'b1);
    wait_idle("contend");
    push(0, 8'hB0, 1'b1, 1'b1);
    push(2, 8'hB2, 1'b1, 1'b1);
    wait_idle("wrap");

    // frame lock: req 0 waits for req 2 to finish
    push(2, 8'hC1, 1'b0, 1'b1);
    push(2, 8'hC2, 1'b0, 1'b1);
    push(2, 8'hC3, 1'b1, 1'b1);
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.req_ready[2]) begin
        ok = 1'b1;
        break;
      end
    end
    check("lock_first_accept", 32'(ok), 1);
    push(0, 8'hD0, 1'b1, 1'b1);
    wait_idle("lock");

    // gap timeout: req 1 stalls after one byte
    push(1, 8'hE0, 1'b0, 1'b1);
    push(2, 8'hF0, 1'b1, 1'b1);
    wait_txdr("gap");
    repeat (19) @(negedge clk);
    check("gap_pre_abort", bus.frame_abort, 0);
    check("gap_pre_grant_valid", bus.grant_valid, 1);
    @(negedge clk);
    check("gap_abort", bus.frame_abort, 1);
    check("gap_abort_grant_valid", bus.grant_valid, 0);
    @(negedge clk);
    check("gap_abort_pulse", bus.frame_abort, 0);
    check("gap_next_grant_valid", bus.grant_valid, 1);
    check("gap_next_grant_id", bus.grant_id, 2);
    wait_idle("gap");
    check("gap_abort_count", abort_cnt, 1);

    // backpressure: tx_done held low while owner is valid
    hold_low = 1'b1;
    push(3, 8'h5A, 1'b1, 1'b1);
    rdy_hits = 0;
    txr_hits = 0;
    abt_hits = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.req_ready != '0) rdy_hits++;
      if (bus.tx_data_ready) txr_hits++;
      if (bus.frame_abort) abt_hits++;
    end
    check("bp_req_ready", rdy_hits, 0);
    check("bp_tx_data_ready", txr_hits, 0);
    check("bp_no_abort", abt_hits, 0);
    check("bp_grant_valid", bus.grant_valid, 1);
    check("bp_grant_id", bus.grant_id, 3);
    hold_low = 1'b0;
    wait_idle("bp");

    // reset mid-frame while in WAIT_HIGH
    push(0, 8'h11, 1'b0, 1'b1);
    push(0, 8'h22, 1'b1, 1'b0);
    wait_txdr("mrst");
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset("mrst");
    for (int i = 0; i < N; i++) tail[i] = head[i];
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_no_abort", abort_cnt, 1);
    wait_idle("mrst");

    // first arbitration after reset
    push(2, 8'h99, 1'b1, 1'b1);
    wait_idle("post_rst");
    check("final_exp_empty", exp_q.size(), 0);
    check("final_abort_count", abort_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
